chunked_adder: RTL and testbench
================================

CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 Parameter WIDTH, default 12: operand and sum width in bits.
REQ-002 Parameter CHUNK, default 3: bits added per clock cycle (ripple slice width).
REQ-003 WIDTH SHALL be an integer multiple of CHUNK, with CHUNK >= 1; NCHUNK = WIDTH/CHUNK.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port in_valid, input, 1: operands and mode are valid.
REQ-007 Port in_ready, output, 1: block accepts operands.
REQ-008 Port a, input, WIDTH: operand A.
REQ-009 Port b, input, WIDTH: operand B.
REQ-010 Port cin, input, 1: carry-in, used only when sub=0.
REQ-011 Port sub, input, 1: 0 = A+B+cin; 1 = A-B, computed as A+~B+1.
REQ-012 Port out_valid, output, 1: result is valid.
REQ-013 Port out_ready, input, 1: consumer accepts the result.
REQ-014 Port sum, output, WIDTH: result, modulo 2^WIDTH.
REQ-015 Port cout, output, 1: carry out of the MSB; for sub=1 this is the not-borrow flag.
REQ-016 Port ovf, output, 1: two's-complement overflow, defined as carry into MSB XOR carry out of MSB.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-018 IDLE: in_ready=1 and out_valid=0; when in_valid=1 the block SHALL capture a, b (or ~b if sub=1) and carry (cin if sub=0, 1 if sub=1), clear the chunk index, and go to RUN.
REQ-019 RUN: in_ready=0; each cycle the block SHALL add chunk[idx] of A, the chunk of the captured B and the carry register, write the CHUNK sum bits into sum[idx*CHUNK +: CHUNK], update the carry register, and increment idx.
REQ-020 On the cycle idx=NCHUNK-1 is processed, the block SHALL record carry-in-to-MSB and carry-out for ovf/cout and go to DONE.
REQ-021 Latency: out_valid SHALL rise exactly NCHUNK cycles after the accept edge.
REQ-022 DONE: out_valid=1 and in_ready=0; sum, cout and ovf SHALL hold stable while out_ready=0.
REQ-023 DONE with out_ready=1: the result is consumed on that edge and the FSM goes to IDLE; a new operand is accepted no earlier than the following cycle (no overlap).
REQ-024 Inputs a, b, cin and sub SHALL be ignored outside the accept cycle; changing them during RUN SHALL NOT affect the result.
REQ-025 CHUNK=WIDTH is legal: NCHUNK=1, latency 1.
REQ-026 sum SHALL be unspecified while out_valid=0; cout and ovf SHALL be valid only with out_valid=1.

Reset
REQ-027 When rst asserts, the block SHALL immediately enter IDLE, including when it asserts mid-RUN or in DONE, and any in-flight operation SHALL be discarded.
REQ-028 Reset values SHALL be: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0; the internal carry and index registers SHALL be 0.
REQ-029 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification (WIDTH=12, CHUNK=3)
REQ-030 a=0xFFF, b=0x001, cin=0, sub=0 -> sum=0x000, cout=1, ovf=0, out_valid 4 cycles after accept.
REQ-031 a=0x0FF, b=0x000, cin=1, sub=0 -> sum=0x100, cout=0, ovf=0.
REQ-032 a=0x7FF, b=0x001, sub=0 -> sum=0x800, cout=0, ovf=1; a=0x005, b=0x007, sub=1 -> sum=0xFFE, cout=0, ovf=0.
REQ-033 Backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid, sum, cout and ovf stay constant and in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-034 rst pulsed during the 2nd RUN cycle -> in_ready=1 and out_valid=0 immediately; the next operation (a=0x123, b=0x456) -> sum=0x579.
REQ-035 Operands toggled randomly during RUN -> result matches the operands captured at accept; random regression of 10k operations checked against the A+B+cin / A-B reference model.

Source files
------------

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: ripples CHUNK bits per clock through a registered carry,
// with a valid/ready handshake on both operand and result sides.
module chunked_adder #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CHUNK = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             c_chunk;
    logic             c_into_top;

    // One ripple slice; b_q already holds ~B when subtracting.
    always_comb begin
        a_chunk = a_q[idx_q*CHUNK +: CHUNK];
        b_chunk = b_q[idx_q*CHUNK +: CHUNK];
        {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_q);
        // Carry into the slice's top bit, recovered from its sum bit.
        c_into_top = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ s_chunk[CHUNK-1];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[idx_q*CHUNK +: CHUNK] = s_chunk;
                carry_d = c_chunk;
                if (idx_q == LAST_IDX) begin
                    cout_d  = c_chunk;
                    ovf_d   = c_into_top ^ c_chunk;
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        sum       = sum_q;
        cout      = cout_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder (WIDTH=12, CHUNK=3): directed vectors, backpressure,
// mid-run reset and a randomized regression against a reference model via a scoreboard.
`timescale 1ns/1ps
module tb_chunked_adder;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned CHUNK = 3;
    localparam int          LAT   = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    chunked_adder #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t model(logic [WIDTH-1:0] ma, logic [WIDTH-1:0] mb, logic mcin,
                                   logic msub);
        exp_t             e;
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        bb   = msub ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + (WIDTH+1)'(msub ? 1'b1 : mcin);
        e.s  = full[WIDTH-1:0];
        e.co = full[WIDTH];
        e.ov = (ma[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
        return e;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic accept(logic [WIDTH-1:0] ta, logic [WIDTH-1:0] tb, logic tcin, logic tsub,
                          exp_t e);
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        cin      = tcin;
        sub      = tsub;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back(e);
    endtask

    task automatic wait_done(string name, bit toggle);
        int   cycles;
        exp_t e;
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            if (toggle) begin
                a   = WIDTH'($urandom);
                b   = WIDTH'($urandom);
                cin = 1'($urandom);
                sub = 1'($urandom);
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        check({name, "_latency"}, cycles, LAT);
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            if (out_valid) begin
                check({name, "_result"}, {sum, cout, ovf}, {e.s, e.co, e.ov});
            end
        end
    endtask

    task automatic drain(string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_idle"}, {in_ready, out_valid}, 2'b10);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0};
        vecs[1] = '{12'h0FF, 12'h000, 1'b1, 1'b0, 12'h100, 1'b0, 1'b0};
        vecs[2] = '{12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1};
        vecs[3] = '{12'h005, 12'h007, 1'b0, 1'b1, 12'hFFE, 1'b0, 1'b0};
        vecs[4] = '{12'h800, 12'h001, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1};
        vecs[5] = '{12'hFFF, 12'hFFF, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0};
        vecs[6] = '{12'h010, 12'h001, 1'b1, 1'b1, 12'h00F, 1'b1, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {in_ready, out_valid, sum, cout, ovf}, {1'b1, 1'b0, 12'h000, 2'b00});
        rst = 1'b0;

        // Directed table; first accept lands on the first edge after reset release.
        for (int i = 0; i < 7; i++) begin
            exp_t e;
            e.s  = vecs[i].s;
            e.co = vecs[i].co;
            e.ov = vecs[i].ov;
            accept(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, e);
            check("run_not_ready", {in_ready, out_valid}, 2'b00);
            wait_done($sformatf("vec%0d", i), 1'b0);
            drain($sformatf("vec%0d", i));
        end

        // Backpressure: result must hold for 5 cycles.
        begin
            exp_t e;
            e = model(12'h3A5, 12'h5C3, 1'b1, 1'b0);
            accept(12'h3A5, 12'h5C3, 1'b1, 1'b0, e);
            wait_done("bp", 1'b0);
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                check($sformatf("bp_hold%0d", i), {out_valid, in_ready, sum, cout, ovf},
                      {1'b1, 1'b0, e.s, e.co, e.ov});
            end
            drain("bp");
        end

        // Reset in the second RUN cycle discards the operation.
        begin
            exp_t e;
            e = model(12'hABC, 12'h111, 1'b0, 1'b0);
            accept(12'hABC, 12'h111, 1'b0, 1'b0, e);
            @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            check("rst_midrun", {in_ready, out_valid, sum, cout, ovf},
                  {1'b1, 1'b0, 12'h000, 2'b00});
            #1;
            rst = 1'b0;
            sb.delete();
            e = model(12'h123, 12'h456, 1'b0, 1'b0);
            check("model_579", e.s, 12'h579);
            accept(12'h123, 12'h456, 1'b0, 1'b0, e);
            wait_done("after_rst", 1'b0);
            drain("after_rst");
        end

        // Random regression with operands toggled during RUN.
        for (int i = 0; i < 10000; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic             rc;
            logic             rs;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            accept(ra, rb, rc, rs, model(ra, rb, rc, rs));
            wait_done("rand", 1'b1);
            drain("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
